// File: rtl/osd_pkg.sv
// Shared types for the OSD character-buffer write path.
// Types and constants only; no logic.
package osd_pkg;
   localparam int CHAR_ROWS  = 2;
   localparam int CHAR_COLS  = 16;
   localparam int OSD_ADDR_W = $clog2(CHAR_ROWS * CHAR_COLS);
   localparam int OSD_DATA_W = 8;

   typedef struct packed {
      logic [OSD_ADDR_W-1:0] addr;
      logic [OSD_DATA_W-1:0] data;
   } osd_wr_t;

   typedef enum logic [1:0] {IDLE, DRAIN, HOLD} osd_sched_st_t;
endpackage

// File: rtl/osd_wr_fifo.sv
// Single-clock FIFO of osd_wr_t, one per requester; clr empties it synchronously.
// Latency: a push is visible at rdat/empty after the push edge.
// Backpressure: a push while full is ignored; a pop while empty is ignored.
module osd_wr_fifo
   import osd_pkg::*;
#(
   parameter int DEPTH = 4
)(
   input  logic    vclk,
   input  logic    rst_i,
   input  logic    clr,
   input  logic    push,
   input  osd_wr_t wdat,
   input  logic    pop,
   output osd_wr_t rdat,
   output logic    full,
   output logic    empty
);
   localparam int AW = $clog2(DEPTH);

   osd_wr_t        mem [DEPTH];
   logic [AW:0]    wr_ptr;
   logic [AW:0]    rd_ptr;
   logic           do_push;
   logic           do_pop;

   // Extra pointer bit distinguishes full from empty when the indices match.
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign empty   = (wr_ptr == rd_ptr);
   assign do_push = push && !full && !clr;
   assign do_pop  = pop && !empty && !clr;
   assign rdat    = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge vclk or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge vclk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= wdat;
   end
endmodule

// File: rtl/osd_char_wr_sched.sv
// Queues OSD char writes per requester and commits them only during vblank (OSD_ARB_FIXED_PRIO_EN: fixed priority, else round-robin).
// Latency: push to buf_we_o is 2 cycles when already draining, vblank rise to first write is 3 cycles.
// Backpressure: req_ready_o[r] drops while FIFO r is full; at most VBLANK_BUDGET writes per vblank (0 = unlimited).
module osd_char_wr_sched
   import osd_pkg::*;
#(
   parameter int NUM_REQ       = 2,
   parameter int FIFO_DEPTH    = 4,
   parameter int ADDR_W        = OSD_ADDR_W,
   parameter int DATA_W        = OSD_DATA_W,
   parameter int VBLANK_BUDGET = 32
)(
   input  logic                       vclk,
   input  logic                       rst_i,
   input  logic                       vblank_i,
   input  logic                       flush_i,
   input  logic [NUM_REQ-1:0]         req_valid_i,
   input  logic [NUM_REQ*ADDR_W-1:0]  req_addr_i,
   input  logic [NUM_REQ*DATA_W-1:0]  req_data_i,
   output logic [NUM_REQ-1:0]         req_ready_o,
   output logic                       buf_we_o,
   output logic [ADDR_W-1:0]          buf_addr_o,
   output logic [DATA_W-1:0]          buf_data_o,
   output logic                       pending_o
);
   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int CNT_W = (VBLANK_BUDGET > 0) ? $clog2(VBLANK_BUDGET + 1) : 1;

   osd_wr_t              wdat [NUM_REQ];
   osd_wr_t              rdat [NUM_REQ];
   logic [NUM_REQ-1:0]   full;
   logic [NUM_REQ-1:0]   empty;
   logic [NUM_REQ-1:0]   push;
   logic [NUM_REQ-1:0]   pop;

   osd_sched_st_t        state;
   logic                 vb_q;
   logic [CNT_W-1:0]     bud_cnt;
   logic                 bud_hit;
   logic                 any_ne;
   logic                 pop_en;
   logic [IDX_W-1:0]     gnt_idx;
   logic                 gnt_found;

   for (genvar r = 0; r < NUM_REQ; r++) begin : g_fifo
      assign wdat[r] = '{addr: req_addr_i[r*ADDR_W +: ADDR_W],
                         data: req_data_i[r*DATA_W +: DATA_W]};

      osd_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
         .vclk  (vclk),
         .rst_i (rst_i),
         .clr   (flush_i),
         .push  (push[r]),
         .wdat  (wdat[r]),
         .pop   (pop[r]),
         .rdat  (rdat[r]),
         .full  (full[r]),
         .empty (empty[r])
      );
   end

   // Ready comes from registered FIFO state only, so a pop cannot open a slot in the same cycle.
   assign req_ready_o = ~full;
   assign push        = req_valid_i & ~full & {NUM_REQ{~flush_i}};
   assign any_ne      = ~&empty;
   assign bud_hit     = (VBLANK_BUDGET != 0) && (bud_cnt == CNT_W'(VBLANK_BUDGET));
   assign pop_en      = (state == DRAIN) && vb_q && any_ne && !bud_hit && !flush_i;
   assign pop         = pop_en ? (NUM_REQ'(1) << gnt_idx) : '0;

`ifdef OSD_ARB_FIXED_PRIO_EN
   always_comb begin
      gnt_idx   = '0;
      gnt_found = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!gnt_found && !empty[IDX_W'(i)]) begin
            gnt_found = 1'b1;
            gnt_idx   = IDX_W'(i);
         end
      end
   end
`else
   logic [IDX_W-1:0] rr_ptr;
   int               cand;

   always_comb begin
      gnt_idx   = '0;
      gnt_found = 1'b0;
      cand      = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand = int'(rr_ptr) + i;
         if (cand >= NUM_REQ) cand = cand - NUM_REQ;
         if (!gnt_found && !empty[IDX_W'(cand)]) begin
            gnt_found = 1'b1;
            gnt_idx   = IDX_W'(cand);
         end
      end
   end

   always_ff @(posedge vclk or posedge rst_i) begin
      if (rst_i)
         rr_ptr <= '0;
      else if (pop_en)
         rr_ptr <= (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
   end
`endif

   always_ff @(posedge vclk or posedge rst_i) begin
      if (rst_i) begin
         state      <= IDLE;
         vb_q       <= 1'b0;
         bud_cnt    <= '0;
         pending_o  <= 1'b0;
         buf_we_o   <= 1'b0;
         buf_addr_o <= '0;
         buf_data_o <= '0;
      end else begin
         vb_q      <= vblank_i;
         pending_o <= any_ne;
         buf_we_o  <= pop_en;
         if (pop_en) begin
            buf_addr_o <= rdat[gnt_idx].addr;
            buf_data_o <= rdat[gnt_idx].data;
         end

         if (!vb_q)
            bud_cnt <= '0;
         else if (pop_en && VBLANK_BUDGET != 0)
            bud_cnt <= bud_cnt + CNT_W'(1);

         if (flush_i) begin
            state <= IDLE;
         end else begin
            case (state)
               IDLE:    if (vb_q && any_ne) state <= DRAIN;
               DRAIN:   if (!vb_q || !any_ne) state <= IDLE;
                        else if (bud_hit)     state <= HOLD;
               HOLD:    if (!vb_q) state <= IDLE;
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_osd_char_wr_sched.sv
// Bench for osd_char_wr_sched: table vectors, directed corner cases, and a random run against a queue model.
module tb_osd_char_wr_sched;
   import osd_pkg::*;

   logic        vclk = 1'b0;
   logic        rst_i = 1'b1;
   logic        vblank_i = 1'b0;
   logic        flush_i = 1'b0;
   logic [1:0]  req_valid_i = '0;
   logic [9:0]  req_addr_i = '0;
   logic [15:0] req_data_i = '0;
   logic [1:0]  req_ready_o, b_ready;
   logic        buf_we_o, b_we;
   logic [4:0]  buf_addr_o, b_addr;
   logic [7:0]  buf_data_o, b_data;
   logic        pending_o, b_pend;

   osd_char_wr_sched dut (
      .vclk(vclk), .rst_i(rst_i), .vblank_i(vblank_i), .flush_i(flush_i),
      .req_valid_i(req_valid_i), .req_addr_i(req_addr_i), .req_data_i(req_data_i),
      .req_ready_o(req_ready_o), .buf_we_o(buf_we_o), .buf_addr_o(buf_addr_o),
      .buf_data_o(buf_data_o), .pending_o(pending_o)
   );

   osd_char_wr_sched #(.VBLANK_BUDGET(3)) dut_b (
      .vclk(vclk), .rst_i(rst_i), .vblank_i(vblank_i), .flush_i(flush_i),
      .req_valid_i(req_valid_i), .req_addr_i(req_addr_i), .req_data_i(req_data_i),
      .req_ready_o(b_ready), .buf_we_o(b_we), .buf_addr_o(b_addr),
      .buf_data_o(b_data), .pending_o(b_pend)
   );

   always #5 vclk = ~vclk;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   osd_wr_t wq[$];
   osd_wr_t wqb[$];
   osd_wr_t exp_q[$];
   int      wt[$];

   always @(posedge vclk) cyc <= cyc + 1;

   always @(negedge vclk) begin
      if (buf_we_o) begin
         wq.push_back(osd_wr_t'({buf_addr_o, buf_data_o}));
         wt.push_back(cyc);
      end
      if (b_we) wqb.push_back(osd_wr_t'({b_addr, b_data}));
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge vclk);
      #1;
   endtask

   function automatic osd_wr_t mk(input int r, input int i);
      osd_wr_t e;
      e.addr = 5'(r * 8 + i);
      e.data = 8'(64 + r * 16 + i);
      return e;
   endfunction

   task automatic set_req(input int r, input osd_wr_t e);
      req_addr_i[r*5 +: 5] = e.addr;
      req_data_i[r*8 +: 8] = e.data;
   endtask

   task automatic do_reset();
      rst_i = 1'b1; vblank_i = 1'b0; flush_i = 1'b0; req_valid_i = '0;
      repeat (2) tick();
      rst_i = 1'b0;
      tick();
      wq.delete(); wqb.delete(); wt.delete();
   endtask

   task automatic fill(input int n0, input int n1);
      for (int i = 0; i < 4; i++) begin
         if (i < n0) begin set_req(0, mk(0, i)); req_valid_i[0] = 1'b1; end
         if (i < n1) begin set_req(1, mk(1, i)); req_valid_i[1] = 1'b1; end
         if (i < n0 || i < n1) tick();
         req_valid_i = '0;
      end
   endtask

   // Expected commit order when all entries are queued up front and the pointer starts at 0.
   task automatic build_exp(input int n0, input int n1);
      int c0, c1, p, g;
      exp_q.delete(); c0 = 0; c1 = 0; p = 0;
      while (c0 < n0 || c1 < n1) begin
`ifdef OSD_ARB_FIXED_PRIO_EN
         g = (c0 < n0) ? 0 : 1;
`else
         if (p == 0) g = (c0 < n0) ? 0 : 1;
         else        g = (c1 < n1) ? 1 : 0;
         p = 1 - g;
`endif
         if (g == 0) begin exp_q.push_back(mk(0, c0)); c0++; end
         else        begin exp_q.push_back(mk(1, c1)); c1++; end
      end
   endtask

   task automatic chk_order(input string nm, input bit use_b, input int from, input int n);
      for (int i = 0; i < n; i++) begin
         osd_wr_t g;
         if (use_b) g = (wqb.size() > from + i) ? wqb[from + i] : '1;
         else       g = (wq.size()  > from + i) ? wq[from + i]  : '1;
         chk(nm, 32'(g), 32'(exp_q[from + i]));
      end
   endtask

   typedef struct {
      int         r;
      logic [4:0] addr;
      logic [7:0] data;
      int         lat;
   } vec_t;
   vec_t vt[4];

   osd_wr_t mq [2][$];
   osd_wr_t ein [2];
   int      vb_run, rr, g;
   int      sz_pre [2];
   bit      vb_now, fl_now, vb1, vb2, f1, ne1, ne_now, exp_we;
   logic [1:0] val;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1);
   end

   initial begin
      vt[0] = '{r: 0, addr: 5'd1,  data: 8'h11, lat: 2};
      vt[1] = '{r: 1, addr: 5'd30, data: 8'hA5, lat: 2};
      vt[2] = '{r: 0, addr: 5'd31, data: 8'hFF, lat: 2};
      vt[3] = '{r: 1, addr: 5'd0,  data: 8'h00, lat: 2};

      // Reset values, checked while reset is held.
      #2;
      chk("rst_we",    32'(buf_we_o),    32'd0);
      chk("rst_addr",  32'(buf_addr_o),  32'd0);
      chk("rst_data",  32'(buf_data_o),  32'd0);
      chk("rst_pend",  32'(pending_o),   32'd0);
      chk("rst_state", 32'(dut.state),   32'(IDLE));
      do_reset();
      chk("rst_ready", 32'(req_ready_o), 32'd3);

      // Single write held back until vblank, then 3 cycles from the rise.
      set_req(0, '{addr: 5'd3, data: 8'h41}); req_valid_i = 2'b01; tick(); req_valid_i = '0;
      repeat (100) tick();
      chk("t1_nowr", 32'(wq.size()), 32'd0);
      chk("t1_pend", 32'(pending_o), 32'd1);
      vblank_i = 1'b1;
      tick(); chk("t1_we1", 32'(buf_we_o), 32'd0);
      tick(); chk("t1_we2", 32'(buf_we_o), 32'd0);
      tick(); chk("t1_we3", 32'(buf_we_o), 32'd1);
      chk("t1_wr", 32'({buf_addr_o, buf_data_o}), 32'({5'd3, 8'h41}));
      tick(); chk("t1_we4", 32'(buf_we_o), 32'd0);
      chk("t1_cnt", 32'(wq.size()), 32'd1);

      // Table: push into empty FIFOs during vblank, write two cycles after the push.
      repeat (3) tick();
      for (int v = 0; v < 4; v++) begin
         set_req(vt[v].r, '{addr: vt[v].addr, data: vt[v].data});
         req_valid_i = 2'b01 << vt[v].r;
         tick(); req_valid_i = '0;
         for (int t = 0; t < 4; t++) begin
            chk("tbl_we", 32'(buf_we_o), 32'(t == vt[v].lat));
            if (t == vt[v].lat)
               chk("tbl_wr", 32'({buf_addr_o, buf_data_o}), 32'({vt[v].addr, vt[v].data}));
            if (t < 3) tick();
         end
         tick();
      end
      vblank_i = 1'b0;

      // Both FIFOs full, then one vblank drains 8 back-to-back writes.
      do_reset();
      fill(4, 4);
      chk("t2_ready", 32'(req_ready_o), 32'd0);
      vblank_i = 1'b1;
      repeat (15) tick();
      build_exp(4, 4);
      chk("t2_cnt", 32'(wq.size()), 32'd8);
      chk_order("t2_order", 1'b0, 0, 8);
      for (int i = 1; i < 8; i++)
         chk("t2_b2b", 32'((wt.size() > i) ? wt[i] - wt[0] : -1), 32'(i));
      chk("t2_pend", 32'(pending_o), 32'd0);
      vblank_i = 1'b0;

      // Budget of 3 per vblank stops in HOLD, remainder commits next vblank.
      do_reset();
      fill(3, 3);
      vblank_i = 1'b1;
      repeat (20) tick();
      build_exp(3, 3);
      chk("t3_cnt1", 32'(wqb.size()), 32'd3);
      chk("t3_hold", 32'(dut_b.state), 32'(HOLD));
      chk("t3_pend", 32'(b_pend), 32'd1);
      vblank_i = 1'b0;
      repeat (3) tick();
      chk("t3_idle", 32'(dut_b.state), 32'(IDLE));
      vblank_i = 1'b1;
      repeat (20) tick();
      chk("t3_cnt2", 32'(wqb.size()), 32'd6);
      chk_order("t3_order", 1'b1, 0, 6);
      vblank_i = 1'b0;

      // vblank dropped after two pops.
      do_reset();
      fill(4, 0);
      vblank_i = 1'b1;
      repeat (3) tick();
      vblank_i = 1'b0;
      repeat (6) tick();
      build_exp(4, 0);
      chk("t4_cnt1", 32'(wq.size()), 32'd2);
      chk("t4_pend", 32'(pending_o), 32'd1);
      vblank_i = 1'b1;
      repeat (10) tick();
      chk("t4_cnt2", 32'(wq.size()), 32'd4);
      chk_order("t4_order", 1'b0, 0, 4);
      vblank_i = 1'b0;

      // Full FIFO refuses a push even on the cycle it pops.
      do_reset();
      fill(0, 4);
      chk("t5_full", 32'(req_ready_o[1]), 32'd0);
      set_req(1, mk(1, 9)); req_valid_i = 2'b10;
      vblank_i = 1'b1;
      tick(); chk("t5_rdy1", 32'(req_ready_o[1]), 32'd0);
      tick(); chk("t5_rdy2", 32'(req_ready_o[1]), 32'd0);
      tick(); chk("t5_rdy3", 32'(req_ready_o[1]), 32'd1);
      chk("t5_we", 32'(buf_we_o), 32'd1);
      req_valid_i = '0;
      repeat (10) tick();
      build_exp(0, 4);
      chk("t5_cnt", 32'(wq.size()), 32'd4);
      chk_order("t5_order", 1'b0, 0, 4);
      vblank_i = 1'b0;

      // Flush mid-drain: in-flight write survives, push on the flush cycle is dropped.
      do_reset();
      fill(3, 3);
      vblank_i = 1'b1;
      repeat (4) tick();
      flush_i = 1'b1; set_req(0, mk(0, 7)); req_valid_i = 2'b01;
      tick();
      flush_i = 1'b0; req_valid_i = '0;
      chk("t6f_we", 32'(buf_we_o), 32'd0);
      repeat (10) tick();
      build_exp(3, 3);
      chk("t6f_cnt", 32'(wq.size()), 32'd2);
      chk_order("t6f_order", 1'b0, 0, 2);
      chk("t6f_pend", 32'(pending_o), 32'd0);
      vblank_i = 1'b0;

      // Reset mid-drain: in-flight write is dropped with the queues.
      do_reset();
      fill(3, 3);
      vblank_i = 1'b1;
      repeat (4) tick();
      rst_i = 1'b1;
      #1;
      chk("t6r_we", 32'(buf_we_o), 32'd0);
      chk("t6r_pend", 32'(pending_o), 32'd0);
      repeat (2) tick();
      rst_i = 1'b0;
      repeat (10) tick();
      chk("t6r_cnt", 32'(wq.size()), 32'd1);
      chk("t6r_ready", 32'(req_ready_o), 32'd3);
      chk("t6r_pend2", 32'(pending_o), 32'd0);
      vblank_i = 1'b0;

      // Random traffic against per-requester queues.
      do_reset();
      mq[0].delete(); mq[1].delete();
      vb_run = 0; rr = 0; vb_now = 0; vb1 = 0; vb2 = 0; f1 = 0; ne1 = 0;
      for (int k = 0; k < 3000; k++) begin
         if ($urandom_range(0, 7) == 0) vb_now = !vb_now;
         if (vb_now) vb_run++; else vb_run = 0;
         if (vb_run > 12) begin vb_now = 0; vb_run = 0; end
         fl_now = ($urandom_range(0, 199) == 0);
         val[0] = ($urandom_range(0, 2) == 0);
         val[1] = ($urandom_range(0, 2) == 0);
         for (int r = 0; r < 2; r++) begin
            ein[r] = osd_wr_t'($urandom_range(0, 8191));
            set_req(r, ein[r]);
         end
         vblank_i = vb_now; flush_i = fl_now; req_valid_i = val;
         ne_now = (mq[0].size() != 0) || (mq[1].size() != 0);
         sz_pre[0] = mq[0].size(); sz_pre[1] = mq[1].size();
         tick();
         exp_we = !fl_now && !f1 && vb1 && vb2 && ne1 && ne_now;
         chk("rnd_we", 32'(buf_we_o), 32'(exp_we));
         chk("rnd_pend", 32'(pending_o), 32'(ne_now));
         if (exp_we) begin
`ifdef OSD_ARB_FIXED_PRIO_EN
            g = (mq[0].size() != 0) ? 0 : 1;
`else
            g = (mq[rr].size() != 0) ? rr : 1 - rr;
            rr = 1 - g;
`endif
            chk("rnd_wr", 32'({buf_addr_o, buf_data_o}), 32'(mq[g][0]));
            void'(mq[g].pop_front());
         end
         if (fl_now) begin
            mq[0].delete(); mq[1].delete();
         end else begin
            for (int r = 0; r < 2; r++)
               if (val[r] && sz_pre[r] < 4) mq[r].push_back(ein[r]);
         end
         chk("rnd_rdy", 32'(req_ready_o), 32'({mq[1].size() < 4, mq[0].size() < 4}));
         vb2 = vb1; vb1 = vb_now; f1 = fl_now; ne1 = ne_now;
      end
      vblank_i = 1'b0; flush_i = 1'b0; req_valid_i = '0;
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
